paver_ps2_rx: RTL and testbench

PAVER_PS2_RX -- requirements
Module: paver_ps2_rx

---
 rtl/paver_ps2_rx_if.sv | 20 ++
 rtl/paver_ps2_rx.sv | 225 ++++++++++++++++++++++
 tb/tb_paver_ps2_rx.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/paver_ps2_rx_if.sv
// Key-event handshake between the PS/2 receiver and its consumer.
// The receiver drives the head FIFO entry and valid; the consumer drives ready.
interface paver_ps2_rx_if;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_brk;
  logic [2:0] key_mods;
  logic       key_valid;
  logic       key_ready;

  modport master (
    output key_code, key_ext, key_brk, key_mods, key_valid,
    input  key_ready
  );

  modport slave (
    input  key_code, key_ext, key_brk, key_mods, key_valid,
    output key_ready
  );
endinterface

// File: rtl/paver_ps2_rx.sv
// PS/2 keyboard receiver: glitch filter, frame FSM, scancode prefix/modifier
// decoder and a show-ahead key-event FIFO.
module paver_ps2_rx #(
  parameter int FILTER_LEN  = 8,
  parameter int FIFO_DEPTH  = 8,
  parameter int TIMEOUT_CYC = 100000,
  parameter int MOD_EVENTS  = 1
) (
  input  logic           coreclk,
  input  logic           reset,
  input  logic           ps2clk,
  input  logic           ps2data,
  input  logic           flush,
  paver_ps2_rx_if.master key,
  output logic [2:0]     mods,
  output logic           overflow,
  output logic [7:0]     err_cnt
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic [1:0]            dataSync_q;
  logic [FILTER_LEN-1:0] filter_q;
  logic                  filtClk_q;
  logic                  strobe;
  logic                  dataBit;

  assign strobe  = filtClk_q && (filter_q == '0);
  assign dataBit = dataSync_q[1];

  always_ff @(posedge coreclk or negedge reset) begin
    if (!reset) begin
      dataSync_q <= 2'b11;
      filter_q   <= '1;
      filtClk_q  <= 1'b1;
    end else begin
      dataSync_q <= {dataSync_q[0], ps2data};
      filter_q   <= {filter_q[FILTER_LEN-2:0], ps2clk};
      if (filter_q == '1) filtClk_q <= 1'b1;
      else if (strobe)    filtClk_q <= 1'b0;
    end
  end

  state_t        state_q, state_d;
  logic [2:0]    bitCnt_q, bitCnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          parity_q, parity_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          frameDone_d, frameErr_d;
  logic          frameDone_q;
  logic [7:0]    byte_q;
  logic [7:0]    errCnt_q;

  always_comb begin
    state_d     = state_q;
    bitCnt_d    = bitCnt_q;
    shift_d     = shift_q;
    parity_d    = parity_q;
    timer_d     = '0;
    frameDone_d = 1'b0;
    frameErr_d  = 1'b0;
    case (state_q)
      IDLE: if (strobe && !dataBit) begin
        state_d  = DATA;
        bitCnt_d = 3'd0;
      end
      DATA: if (strobe) begin
        shift_d  = {dataBit, shift_q[7:1]};
        bitCnt_d = bitCnt_q + 3'd1;
        if (bitCnt_q == 3'd7) state_d = PARITY;
      end
      PARITY: if (strobe) begin
        parity_d = dataBit;
        state_d  = STOP;
      end
      STOP: if (strobe) begin
        state_d = IDLE;
        if ((^shift_q ^ parity_q) && dataBit) frameDone_d = 1'b1;
        else                                  frameErr_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    // A stalled partial frame is abandoned once the gap between strobes grows too long.
    if (state_q != IDLE && !strobe) begin
      if (timer_q == TW'(TIMEOUT_CYC - 1)) begin
        state_d    = IDLE;
        frameErr_d = 1'b1;
      end else begin
        timer_d = timer_q + TW'(1);
      end
    end
  end

  always_ff @(posedge coreclk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      bitCnt_q    <= '0;
      shift_q     <= '0;
      parity_q    <= 1'b0;
      timer_q     <= '0;
      frameDone_q <= 1'b0;
      byte_q      <= '0;
      errCnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      bitCnt_q    <= bitCnt_d;
      shift_q     <= shift_d;
      parity_q    <= parity_d;
      timer_q     <= timer_d;
      frameDone_q <= frameDone_d;
      if (frameDone_d) byte_q <= shift_q;
      if (frameErr_d && errCnt_q != 8'hFF) errCnt_q <= errCnt_q + 8'd1;
    end
  end

  logic        ext_q, ext_d, brk_q, brk_d;
  logic        shiftL_q, shiftL_d, shiftR_q, shiftR_d;
  logic        ctrl_q, ctrl_d, alt_q, alt_d;
  logic        push_q, push_d;
  logic [12:0] evt_q;
  logic        isMod;

  assign isMod = (byte_q == 8'h12) || (byte_q == 8'h59) ||
                 (byte_q == 8'h14) || (byte_q == 8'h11);

  always_comb begin
    ext_d    = ext_q;
    brk_d    = brk_q;
    shiftL_d = shiftL_q;
    shiftR_d = shiftR_q;
    ctrl_d   = ctrl_q;
    alt_d    = alt_q;
    push_d   = 1'b0;
    if (frameDone_q) begin
      if (byte_q == 8'hE0)      ext_d = 1'b1;
      else if (byte_q == 8'hF0) brk_d = 1'b1;
      else begin
        case (byte_q)
          8'h12:   shiftL_d = !brk_q;
          8'h59:   shiftR_d = !brk_q;
          8'h14:   ctrl_d   = !brk_q;
          8'h11:   alt_d    = !brk_q;
          default: ;
        endcase
        push_d = (MOD_EVENTS != 0) || !isMod;
        ext_d  = 1'b0;
        brk_d  = 1'b0;
      end
    end
    if (flush) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end
  end

  always_ff @(posedge coreclk or negedge reset) begin
    if (!reset) begin
      ext_q    <= 1'b0;
      brk_q    <= 1'b0;
      shiftL_q <= 1'b0;
      shiftR_q <= 1'b0;
      ctrl_q   <= 1'b0;
      alt_q    <= 1'b0;
      push_q   <= 1'b0;
      evt_q    <= '0;
    end else begin
      ext_q    <= ext_d;
      brk_q    <= brk_d;
      shiftL_q <= shiftL_d;
      shiftR_q <= shiftR_d;
      ctrl_q   <= ctrl_d;
      alt_q    <= alt_d;
      push_q   <= push_d;
      if (push_d) evt_q <= {brk_q, ext_q, byte_q, alt_d, ctrl_d, shiftL_d | shiftR_d};
    end
  end

  assign mods = {alt_q, ctrl_q, shiftL_q | shiftR_q};

  logic [12:0] mem_q [FIFO_DEPTH];
  logic [AW:0] wrPtr_q, rdPtr_q;
  logic        overflow_q;
  logic        empty, full, doPush, doPop, doWrite;
  logic [12:0] head;

  assign empty   = (wrPtr_q == rdPtr_q);
  assign full    = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
  assign doPush  = push_q && !flush;
  assign doPop   = !empty && key.key_ready && !flush;
  assign doWrite = doPush && (!full || doPop);

  always_ff @(posedge coreclk or negedge reset) begin
    if (!reset) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      overflow_q <= 1'b0;
    end else if (flush) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (doWrite)     wrPtr_q    <= wrPtr_q + 1'b1;
      else if (doPush) overflow_q <= 1'b1;
      if (doPop)       rdPtr_q    <= rdPtr_q + 1'b1;
    end
  end

  always_ff @(posedge coreclk) begin
    if (doWrite) mem_q[wrPtr_q[AW-1:0]] <= evt_q;
  end

  // Head fields are forced to zero while empty so stale entries never leak out.
  assign head          = empty ? 13'd0 : mem_q[rdPtr_q[AW-1:0]];
  assign key.key_valid = !empty;
  assign key.key_brk   = head[12];
  assign key.key_ext   = head[11];
  assign key.key_code  = head[10:3];
  assign key.key_mods  = head[2:0];
  assign overflow      = overflow_q;
  assign err_cnt       = errCnt_q;

endmodule

// File: tb/tb_paver_ps2_rx.sv
// Randomised testbench for paver_ps2_rx: drives PS/2 frames on the pins and
// checks decoded events against a scancode-level model kept in queues.
module tb_paver_ps2_rx;

  localparam int FILTER_LEN  = 8;
  localparam int FIFO_DEPTH  = 8;
  localparam int TIMEOUT_CYC = 400;
  localparam int HALF        = 20;

  logic       coreclk = 1'b0;
  logic       reset;
  logic       ps2clk;
  logic       ps2data;
  logic       flush;
  logic [2:0] mods;
  logic       overflow;
  logic [7:0] err_cnt;

  paver_ps2_rx_if kif ();

  paver_ps2_rx #(
    .FILTER_LEN (FILTER_LEN),
    .FIFO_DEPTH (FIFO_DEPTH),
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .MOD_EVENTS (1)
  ) dut (
    .coreclk (coreclk),
    .reset   (reset),
    .ps2clk  (ps2clk),
    .ps2data (ps2data),
    .flush   (flush),
    .key     (kif),
    .mods    (mods),
    .overflow(overflow),
    .err_cnt (err_cnt)
  );

  always #5 coreclk = ~coreclk;

  int checks   = 0;
  int failures = 0;

  // Model state: events are {brk, ext, code[7:0], mods[2:0]}.
  logic [12:0] expQ[$];
  bit          mExt, mBrk, mShL, mShR, mCtrl, mAlt, mOvf;
  int          mErr;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] modelMods();
    return {mAlt, mCtrl, mShL | mShR};
  endfunction

  function automatic void modelReset();
    expQ.delete();
    {mExt, mBrk, mShL, mShR, mCtrl, mAlt, mOvf} = '0;
    mErr = 0;
  endfunction

  function automatic void modelFlush();
    expQ.delete();
    mExt = 0;
    mBrk = 0;
    mOvf = 0;
  endfunction

  function automatic void modelByte(input logic [7:0] b);
    bit make;
    if (b == 8'hE0) mExt = 1;
    else if (b == 8'hF0) mBrk = 1;
    else begin
      make = !mBrk;
      if (b == 8'h12) mShL = make;
      if (b == 8'h59) mShR = make;
      if (b == 8'h14) mCtrl = make;
      if (b == 8'h11) mAlt = make;
      if (expQ.size() < FIFO_DEPTH) expQ.push_back({mBrk, mExt, b, modelMods()});
      else mOvf = 1;
      mExt = 0;
      mBrk = 0;
    end
  endfunction

  // Drives nBits of a frame; optional short low glitches in the data-bit high phases.
  task automatic applyStimulus(input logic [7:0] b, input bit badPar, input int nBits,
                               input bit glitch, input bit measureLat, output int lat);
    logic [10:0] frame;
    int g;
    frame = {1'b1, (~^b) ^ badPar, b, 1'b0};
    lat = -1;
    for (int i = 0; i < nBits; i++) begin
      ps2data = frame[i];
      repeat (HALF / 2) @(negedge coreclk);
      if (glitch && i >= 1 && i <= 8) begin
        g = $urandom_range(FILTER_LEN - 1, 1);
        ps2clk = 1'b0;
        repeat (g) @(negedge coreclk);
        ps2clk = 1'b1;
      end
      repeat (HALF / 2) @(negedge coreclk);
      ps2clk = 1'b0;
      for (int c = 1; c <= HALF; c++) begin
        @(negedge coreclk);
        if (measureLat && i == 10 && lat < 0 && kif.key_valid) lat = c;
      end
      ps2clk = 1'b1;
    end
    ps2data = 1'b1;
    repeat (HALF) @(negedge coreclk);
  endtask

  task automatic sendByte(input logic [7:0] b, input bit glitch);
    int lat;
    applyStimulus(b, 1'b0, 11, glitch, 1'b0, lat);
    modelByte(b);
  endtask

  task automatic drainEvents();
    logic [12:0] e;
    int waitCnt;
    @(negedge coreclk);
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      waitCnt = 0;
      while (!kif.key_valid && waitCnt < 20) begin
        @(negedge coreclk);
        waitCnt++;
      end
      checkOutput("evt_valid", kif.key_valid, 1);
      checkOutput("evt_code", kif.key_code, e[10:3]);
      checkOutput("evt_flags", {kif.key_brk, kif.key_ext}, e[12:11]);
      checkOutput("evt_mods", kif.key_mods, e[2:0]);
      kif.key_ready = 1'b1;
      @(negedge coreclk);
      kif.key_ready = 1'b0;
    end
    checkOutput("drain_empty", kif.key_valid, 0);
  endtask

  task automatic pulseFlush();
    @(negedge coreclk);
    flush = 1'b1;
    @(negedge coreclk);
    flush = 1'b0;
    modelFlush();
  endtask

  initial begin
    int lat;
    logic [7:0] b;
    logic [7:0] seq039 [6];
    logic [7:0] seq040 [5];
    logic [7:0] pool [6];
    seq039 = '{8'h12, 8'h1C, 8'hF0, 8'h1C, 8'hF0, 8'h12};
    seq040 = '{8'hE0, 8'h11, 8'hE0, 8'hF0, 8'h11};
    pool   = '{8'h12, 8'h59, 8'h14, 8'h11, 8'hE0, 8'hF0};

    reset = 1'b0;
    ps2clk = 1'b1;
    ps2data = 1'b1;
    flush = 1'b0;
    kif.key_ready = 1'b0;
    modelReset();
    repeat (3) @(negedge coreclk);
    checkOutput("rst_valid", kif.key_valid, 0);
    checkOutput("rst_code", kif.key_code, 0);
    checkOutput("rst_kmods", kif.key_mods, 0);
    checkOutput("rst_mods", mods, 0);
    checkOutput("rst_ovf", overflow, 0);
    checkOutput("rst_err", err_cnt, 0);
    reset = 1'b1;
    repeat (5) @(negedge coreclk);

    kif.key_ready = 1'b1;
    repeat (2) @(negedge coreclk);
    checkOutput("pop_empty", kif.key_valid, 0);
    kif.key_ready = 1'b0;

    applyStimulus(8'h1C, 1'b0, 11, 1'b0, 1'b1, lat);
    modelByte(8'h1C);
    checkOutput("latency", lat, FILTER_LEN + 3);
    drainEvents();

    foreach (seq039[i]) sendByte(seq039[i], 1'b0);
    drainEvents();
    checkOutput("mods_039", mods, modelMods());

    foreach (seq040[i]) sendByte(seq040[i], 1'b0);
    drainEvents();
    checkOutput("mods_040", mods, modelMods());

    applyStimulus(8'h2D, 1'b1, 11, 1'b0, 1'b0, lat);
    mErr++;
    applyStimulus(8'h55, 1'b0, 5, 1'b0, 1'b0, lat);
    repeat (TIMEOUT_CYC + 2 * HALF) @(negedge coreclk);
    mErr++;
    checkOutput("err_cnt_041", err_cnt, mErr);
    checkOutput("no_evt_041", kif.key_valid, 0);
    sendByte(8'h34, 1'b0);
    drainEvents();

    for (int i = 0; i < FIFO_DEPTH + 2; i++) sendByte(8'($urandom_range(8'h7E, 8'h15)), 1'b0);
    checkOutput("ovf_set", overflow, mOvf);
    drainEvents();
    pulseFlush();
    checkOutput("ovf_flush", overflow, 0);

    sendByte(8'h1C, 1'b0);
    sendByte(8'h32, 1'b0);
    pulseFlush();
    checkOutput("flush_empty", kif.key_valid, 0);
    sendByte(8'hE0, 1'b0);
    pulseFlush();
    sendByte(8'h23, 1'b0);
    drainEvents();

    sendByte(8'h3A, 1'b1);
    drainEvents();

    for (int n = 0; n < 8; n++) begin
      for (int k = 0; k < 4; k++) begin
        if ($urandom_range(1, 0) == 1) b = pool[$urandom_range(5, 0)];
        else b = 8'($urandom_range(8'h7F, 8'h01));
        if ($urandom_range(7, 0) == 0) begin
          applyStimulus(b, 1'b1, 11, 1'($urandom_range(1, 0)), 1'b0, lat);
          mErr++;
        end else begin
          sendByte(b, 1'($urandom_range(1, 0)));
        end
      end
      drainEvents();
      checkOutput("rnd_mods", mods, modelMods());
      checkOutput("rnd_err", err_cnt, mErr);
    end

    sendByte(8'h14, 1'b0);
    applyStimulus(8'h77, 1'b0, 4, 1'b0, 1'b0, lat);
    reset = 1'b0;
    @(negedge coreclk);
    checkOutput("midrst_valid", kif.key_valid, 0);
    checkOutput("midrst_mods", mods, 0);
    checkOutput("midrst_err", err_cnt, 0);
    reset = 1'b1;
    modelReset();
    repeat (5) @(negedge coreclk);
    sendByte(8'h2B, 1'b0);
    drainEvents();
    checkOutput("post_rst_err", err_cnt, mErr);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
